// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/breakpoint clock-enable controller with debounced buttons and LED channel select
module cpu_run_ctrl #(
  parameter int PC_W       = 8,
  parameter int DIV_MAX    = 25000000,
  parameter int DEB_CYCLES = 250000,
  parameter int N_CH       = 4,
  parameter int CH_W       = 8,
  parameter int LED_W      = 4,
  localparam int SEL_W     = $clog2(N_CH)
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 btn_run_n,
  input  logic                 btn_step_n,
  input  logic                 btn_mode_n,
  input  logic [PC_W-1:0]      pc,
  input  logic [PC_W-1:0]      bp_addr,
  input  logic                 bp_en,
  input  logic                 halt_req,
  input  logic [N_CH*CH_W-1:0] ch_data,
  output logic                 cpu_ce,
  output logic [1:0]           state,
  output logic [SEL_W-1:0]     disp_sel,
  output logic [LED_W-1:0]     led
);
  localparam int DEB_W = $clog2(DEB_CYCLES);
  localparam int DIV_W = $clog2(DIV_MAX);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);
  localparam logic [1:0] S_HALT = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;
  localparam logic [1:0] S_BRK  = 2'b11;

  logic [2:0]       btn, sync1_q, sync2_q, deb_q, deb_d, ev_q, ev_d;
  logic [DEB_W-1:0] cnt_q [3];
  logic [DEB_W-1:0] cnt_d [3];
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       state_q, state_d;
  logic             ce_q, ce_d, skip_q, skip_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             run_ev, step_ev, mode_ev, tick, bp_hit;

  assign btn = {btn_mode_n, btn_step_n, btn_run_n};
  assign {mode_ev, step_ev, run_ev} = ev_q;
  assign tick = div_q == DIV_LAST;
  assign bp_hit = bp_en && pc == bp_addr && !skip_q;
  assign cpu_ce = ce_q;
  assign state = state_q;
  assign disp_sel = sel_q;
  assign led = ch_data[sel_q*CH_W +: LED_W];

  // a level is accepted only after DEB_CYCLES samples in a row disagree with it
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_d[i] = deb_q[i];
      ev_d[i] = 1'b0;
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
          ev_d[i] = ~sync2_q[i];
        end else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    sel_d = !mode_ev ? sel_q : sel_q == SEL_LAST ? '0 : sel_q + 1'b1;
    state_d = state_q;
    ce_d = 1'b0;
    skip_d = skip_q;
    case (state_q)
      S_HALT: state_d = run_ev ? S_RUN : step_ev ? S_STEP : S_HALT;
      S_RUN:
        if (run_ev || halt_req) state_d = S_HALT;
        else if (tick && bp_hit) state_d = S_BRK;
        else if (tick) begin
          ce_d = 1'b1;
          skip_d = 1'b0;
        end
      S_STEP: begin
        ce_d = 1'b1;
        state_d = S_HALT;
      end
      // resuming from a breakpoint lets the instruction at bp_addr run once
      default:
        if (run_ev) begin
          state_d = S_RUN;
          skip_d = 1'b1;
        end else if (step_ev) state_d = S_STEP;
    endcase
  end

  always_ff @(posedge CLK or posedge rst)
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q <= '1;
      ev_q <= '0;
      cnt_q <= '{default: '0};
      div_q <= '0;
      state_q <= S_HALT;
      ce_q <= 1'b0;
      skip_q <= 1'b0;
      sel_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      deb_q <= deb_d;
      ev_q <= ev_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      state_q <= state_d;
      ce_q <= ce_d;
      skip_q <= skip_d;
      sel_q <= sel_d;
    end
endmodule
